shift_register_piso: RTL and testbench
======================================

# shift_register_piso

Parallel-in, serial-out operand shifter for the serial adder datapath. It accepts a WIDTH-bit word over a valid/ready load handshake. It then presents the word LSB-first on a single serial line, one bit per `enable` strobe, followed by EXT_BITS fill bits (zero or sign). LSB-first order means a right-shifting serial-in receiver clocked by the same `enable` ends holding bit 0 in position 0. It is the transmit end of the serial operand interface.

## Interface
- WIDTH, 8, parallel word width; must be ≥ 2
- EXT_BITS, 1, fill bits appended after the word; ≥ 0. TOTAL = WIDTH + EXT_BITS
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset; has priority over every other input
- load_valid  in  1  parallel word offered
- load_ready  out  1  shifter idle, can accept a word
- data  in  WIDTH  parallel word, sampled when load_valid && load_ready
- sign_ext  in  1  sampled with data; 1 = fill with data[WIDTH-1], 0 = fill with 0
- enable  in  1  consume current serial bit, advance to next
- serial_out  out  1  current bit
- bit_valid  out  1  serial_out holds a valid bit
- last  out  1  current bit is bit TOTAL-1
- done  out  1  one-cycle pulse after the final bit is consumed

## Operation
- State: 2-state FSM (IDLE, SHIFT), WIDTH-bit shift register `shreg`, registered fill bit, and a bit counter `cnt` of width clog2(TOTAL+1).
- IDLE:
  - Outputs: load_ready=1, bit_valid=0, last=0, serial_out=0. `enable` is ignored.
  - On load_valid: shreg←data, fill←sign_ext ? data[WIDTH-1] : 0, cnt←0, go to SHIFT.
- SHIFT:
  - Outputs: load_ready=0, bit_valid=1, serial_out=shreg[0], last=(cnt==TOTAL-1).
  - load_valid is ignored; data is not sampled.
  - With enable=1 and cnt<TOTAL-1: shreg←{fill, shreg[WIDTH-1:1]}, cnt←cnt+1.
  - With enable=1 and cnt==TOTAL-1: go to IDLE, done←1 for one cycle.
  - With enable=0: all state held; the bit stays on serial_out indefinitely.
- Bits WIDTH..TOTAL-1 equal the fill bit. With EXT_BITS=0, the word ends after bit WIDTH-1.
- done is registered. It is high exactly in the first IDLE cycle after the transfer, and 0 in every other cycle.
- Reset (any state, any cycle): next cycle is IDLE with load_ready=1 and bit_valid=last=done=serial_out=0; shreg, fill and cnt are cleared. An aborted transfer produces no done.

## Timing
- Load accepted at edge k: bit 0 is valid on serial_out in cycle k+1 (latency 1).
- With enable held high, bit i is presented in cycle k+1+i. last is high in cycle k+TOTAL. done and load_ready are high in cycle k+TOTAL+1.
- Back-to-back: a load offered in the done cycle is accepted. The next word's bit 0 appears one cycle later, so throughput is TOTAL+1 cycles per word.
- Downstream samples serial_out on edges where enable && bit_valid. Exactly TOTAL such edges occur per word.
- rst and load_valid in the same cycle: reset wins and the word is not captured.

## Test plan
- Reset: assert rst 2 cycles with load_valid=1 and enable=1 → load_ready=1, bit_valid=0, done=0, serial_out=0; no load captured.
- Load 0xA5, sign_ext=0, enable held 1 (WIDTH=8, EXT_BITS=1) → serial_out 1,0,1,0,0,1,0,1,0 in cycles k+1..k+9; last only in k+9; done only in k+10.
- Load 0x85, sign_ext=1 → serial_out 1,0,1,0,0,0,0,1,1 (ninth bit = sign). Load 0x05, sign_ext=1 → ninth bit 0.
- Enable gaps: load 0x3C, toggle enable 1,0,0,1,… → each bit held through the low-enable cycles; sequence 0,0,1,1,1,1,0,0,0; exactly 9 consumed bits; done once.
- Reset mid-word: load 0xFF, rst after 4 consumed bits → IDLE next cycle, no done pulse. Load 0x01 afterwards → sequence 1,0,0,0,0,0,0,0,0.
- load_valid held high with 0x11 then 0x22 during SHIFT → 0x22 is ignored until the done cycle, accepted there, and its first bit (0) appears the following cycle.

Source files
------------

// File: rtl/shift_register_piso.sv
// Parallel-in, serial-out operand shifter: loads a word over valid/ready and
// streams it LSB-first, one bit per enable, followed by EXT_BITS fill bits.
module shift_register_piso #(
   parameter int WIDTH    = 8,
   parameter int EXT_BITS = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] data,
   input  logic             sign_ext,
   input  logic             enable,
   output logic             serial_out,
   output logic             bit_valid,
   output logic             last,
   output logic             done
);

   localparam int TOTAL = WIDTH + EXT_BITS;
   localparam int CW    = $clog2(TOTAL + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(TOTAL - 1);

   typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] shreg;
   logic             fill;
   logic [CW-1:0]    cnt;

   logic accept, advance, finish;

   assign accept  = (state == IDLE) && load_valid;
   assign advance = (state == SHIFT) && enable && (cnt != LAST_CNT);
   assign finish  = (state == SHIFT) && enable && (cnt == LAST_CNT);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      load_ready = 1'b0;
      bit_valid  = 1'b0;
      serial_out = 1'b0;
      last       = 1'b0;
      case (state)
         IDLE: begin
            load_ready = 1'b1;
            if (load_valid) state_next = SHIFT;
         end
         SHIFT: begin
            bit_valid  = 1'b1;
            serial_out = shreg[0];
            last       = (cnt == LAST_CNT);
            if (finish) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Fill bit shifts in from the top so bits WIDTH..TOTAL-1 read as fill.
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg <= '0;
         fill  <= 1'b0;
         cnt   <= '0;
         done  <= 1'b0;
      end else begin
         done <= finish;
         if (accept) begin
            shreg <= data;
            fill  <= sign_ext & data[WIDTH-1];
            cnt   <= '0;
         end else if (advance) begin
            shreg <= {fill, shreg[WIDTH-1:1]};
            cnt   <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_shift_register_piso.sv
// Bench for shift_register_piso: directed plan steps then random traffic,
// checked against a queue-of-expected-bits reference model.
module tb_shift_register_piso;

   localparam int W = 8;
   localparam int E = 1;
   localparam int T = W + E;

   logic         clk = 1'b0;
   logic         rst, load_valid, sign_ext, enable;
   logic [W-1:0] data;
   logic         load_ready, serial_out, bit_valid, last, done;

   int checks   = 0;
   int failures = 0;

   bit q[$];
   bit exp_done;
   int done_cnt;

   always #5 clk = ~clk;

   shift_register_piso #(.WIDTH(W), .EXT_BITS(E)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .data       (data),
      .sign_ext   (sign_ext),
      .enable     (enable),
      .serial_out (serial_out),
      .bit_valid  (bit_valid),
      .last       (last),
      .done       (done)
   );

   task automatic chk(input string tag, input logic obs, input logic expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, expv, $time);
      end
   endtask

   task automatic check_outputs();
      int n = q.size();
      chk("load_ready", load_ready, n == 0);
      chk("bit_valid",  bit_valid,  n != 0);
      chk("serial_out", serial_out, (n != 0) ? q[0] : 1'b0);
      chk("last",       last,       n == 1);
      chk("done",       done,       exp_done);
   endtask

   // Check the current cycle, drive the next inputs, then advance the model
   // by one clock using the inputs the DUT samples on that edge.
   task automatic step(input logic r, input logic lv, input logic [W-1:0] d,
                       input logic se, input logic en);
      @(negedge clk);
      check_outputs();
      rst = r; load_valid = lv; data = d; sign_ext = se; enable = en;
      @(posedge clk);
      if (r) begin
         q.delete();
         exp_done = 1'b0;
      end else if (q.size() == 0) begin
         exp_done = 1'b0;
         if (lv)
            for (int i = 0; i < T; i++)
               q.push_back((i < W) ? d[i] : (se & d[W-1]));
      end else if (en) begin
         void'(q.pop_front());
         exp_done = (q.size() == 0);
      end else begin
         exp_done = 1'b0;
      end
      if (exp_done) done_cnt++;
   endtask

   initial begin
      bit [3:0] pat;
      rst = 1'b1; load_valid = 1'b0; data = '0; sign_ext = 1'b0; enable = 1'b0;
      exp_done = 1'b0; done_cnt = 0;
      @(posedge clk);

      // reset with load_valid and enable asserted: nothing captured
      step(1, 1, 8'hFF, 1, 1);
      step(1, 1, 8'hFF, 1, 1);
      step(0, 0, 8'h00, 0, 0);

      // 0xA5 zero fill, enable held
      step(0, 1, 8'hA5, 0, 1);
      repeat (T + 1) step(0, 0, 8'h00, 0, 1);

      // sign fill with msb set, then clear
      step(0, 1, 8'h85, 1, 1);
      repeat (T + 1) step(0, 0, 8'h00, 0, 1);
      step(0, 1, 8'h05, 1, 1);
      repeat (T + 1) step(0, 0, 8'h00, 0, 1);

      // enable gaps 1,0,0,1,...
      done_cnt = 0;
      pat = 4'b1001;
      step(0, 1, 8'h3C, 0, 0);
      for (int i = 0; i < 40; i++) step(0, 0, 8'h00, 0, pat[i % 4]);
      checks++;
      assert (done_cnt == 1) else begin
         failures++;
         $error("FAIL gap_done_count observed=%0d expected=1", done_cnt);
      end

      // abort mid-word after 4 consumed bits: no done
      done_cnt = 0;
      step(0, 1, 8'hFF, 0, 0);
      repeat (4) step(0, 0, 8'h00, 0, 1);
      step(1, 0, 8'h00, 0, 1);
      repeat (3) step(0, 0, 8'h00, 0, 1);
      checks++;
      assert (done_cnt == 0) else begin
         failures++;
         $error("FAIL abort_done observed=%0d expected=0", done_cnt);
      end
      step(0, 1, 8'h01, 0, 1);
      repeat (T + 1) step(0, 0, 8'h00, 0, 1);

      // load_valid held: second word waits for the done cycle
      step(0, 1, 8'h11, 0, 1);
      repeat (2 * T + 2) step(0, 1, 8'h22, 0, 1);
      repeat (T + 2) step(0, 0, 8'h00, 0, 1);

      // random traffic
      for (int i = 0; i < 600; i++)
         step(($urandom_range(0, 49) == 0), $urandom_range(0, 1),
              W'($urandom), $urandom_range(0, 1), ($urandom_range(0, 9) < 7));

      step(0, 0, 8'h00, 0, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
